// File: rtl/edge_pkg.sv
// Shared constants and types for the edge pipeline (sobel, bbox scan, display).
// Frame geometry, datapath widths, scan FSM states and the BRAM tag bundle.
package edge_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int ADDR_W       = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int SUM_W        = 28;
  localparam int READ_LATENCY = 2;
  localparam int MIN_COUNT    = 16;
  localparam int DIV_CNT_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } state_t;

  // Coordinates travelling alongside an outstanding BRAM read.
  typedef struct packed {
    logic           v;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } tag_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: SUM_W-bit dividend by ADDR_W-bit divisor, one bit/cycle.
// Ports: clk, rst, go (load), dividend, divisor, quotient (low Q_W bits), div_done pulse.
module seq_divider
  import edge_pkg::*;
#(
  parameter int Q_W = X_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [SUM_W-1:0]  dividend,
  input  logic [ADDR_W-1:0] divisor,
  output logic [Q_W-1:0]    quotient,
  output logic              div_done
);

  logic [SUM_W-1:0]     q;
  logic [ADDR_W-1:0]    rem;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 run;
  logic [ADDR_W:0]      rem_sh;
  logic [ADDR_W:0]      diff;

  // rem < divisor always holds, so the trial difference fits in ADDR_W+1
  // bits and its top bit is the "does not fit" flag.
  assign rem_sh   = {rem, q[SUM_W-1]};
  assign diff     = rem_sh - {1'b0, divisor};
  assign quotient = q[Q_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      rem      <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (go) begin
        q   <= dividend;
        rem <= '0;
        cnt <= DIV_CNT_W'(SUM_W);
        run <= 1'b1;
      end else if (run) begin
        if (!diff[ADDR_W]) begin
          rem <= diff[ADDR_W-1:0];
          q   <= {q[SUM_W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[ADDR_W-1:0];
          q   <= {q[SUM_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == DIV_CNT_W'(1)) begin
          run      <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/edge_bbox_scan.sv
// Raster-scans the edge BRAM after sobel finishes; reports edge count, bbox, centroid.
// Ports: clk, rst, start, edge_data in; edge_memory_addr, busy, done, found,
// count, x_min/x_max, y_min/y_max, x_centroid, y_centroid out.
//
// Latency: counting the first clock edge that samples start high as edge 1,
// done is first high after edge 1 + WIDTH*HEIGHT + READ_LATENCY + 60
// (two 30-cycle divisions). A frame with no edge pixels skips the divisions
// and finishes after edge 1 + WIDTH*HEIGHT + READ_LATENCY.
module edge_bbox_scan #(
  parameter int WIDTH        = edge_pkg::WIDTH,
  parameter int HEIGHT       = edge_pkg::HEIGHT,
  parameter int READ_LATENCY = edge_pkg::READ_LATENCY,
  parameter int MIN_COUNT    = edge_pkg::MIN_COUNT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  edge_data,
  output logic [edge_pkg::ADDR_W-1:0] edge_memory_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [edge_pkg::ADDR_W-1:0] count,
  output logic [edge_pkg::X_W-1:0]    x_min,
  output logic [edge_pkg::X_W-1:0]    x_max,
  output logic [edge_pkg::Y_W-1:0]    y_min,
  output logic [edge_pkg::Y_W-1:0]    y_max,
  output logic [edge_pkg::X_W-1:0]    x_centroid,
  output logic [edge_pkg::Y_W-1:0]    y_centroid
);

  import edge_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] MIN_CNT   = ADDR_W'(MIN_COUNT);
  localparam logic [3:0]        DRAIN_END = 4'(READ_LATENCY - 1);

  state_t            state;
  logic              start_d;
  logic              start_edge;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  tag_t              pipe [READ_LATENCY];
  tag_t              smp;
  logic              hit;
  logic [SUM_W-1:0]  x_sum;
  logic [SUM_W-1:0]  y_sum;
  logic [3:0]        drain_cnt;
  logic              div_go;
  logic              div_done;
  logic [SUM_W-1:0]  dividend;
  logic [X_W-1:0]    quotient;

  assign start_edge = start & ~start_d;
  assign smp        = pipe[READ_LATENCY-1];
  assign hit        = smp.v && (edge_data != 4'd0);
  assign dividend   = (state == ST_DIV_Y) ? y_sum : x_sum;

  seq_divider #(
    .Q_W (X_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go),
    .dividend (dividend),
    .divisor  (count),
    .quotient (quotient),
    .div_done (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      start_d          <= 1'b0;
      x                <= '0;
      y                <= '0;
      x_sum            <= '0;
      y_sum            <= '0;
      drain_cnt        <= '0;
      div_go           <= 1'b0;
      edge_memory_addr <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      found            <= 1'b0;
      count            <= '0;
      x_min            <= '0;
      x_max            <= '0;
      y_min            <= '0;
      y_max            <= '0;
      x_centroid       <= '0;
      y_centroid       <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      start_d <= start;
      div_go  <= 1'b0;

      // Tag each issued address so its data returns with its coordinates.
      pipe[0] <= tag_t'{v: (state == ST_SCAN), x: x, y: y};
      for (int i = 1; i < READ_LATENCY; i++)
        pipe[i] <= pipe[i-1];

      if (hit) begin
        count <= count + 1'b1;
        x_sum <= x_sum + SUM_W'(smp.x);
        y_sum <= y_sum + SUM_W'(smp.y);
        if (smp.x < x_min) x_min <= smp.x;
        if (smp.x > x_max) x_max <= smp.x;
        if (smp.y < y_min) y_min <= smp.y;
        if (smp.y > y_max) y_max <= smp.y;
      end

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state            <= ST_SCAN;
            busy             <= 1'b1;
            done             <= 1'b0;
            found            <= 1'b0;
            count            <= '0;
            x_sum            <= '0;
            y_sum            <= '0;
            x_min            <= X_LAST;
            y_min            <= Y_LAST;
            x_max            <= '0;
            y_max            <= '0;
            x_centroid       <= '0;
            y_centroid       <= '0;
            edge_memory_addr <= '0;
            x                <= '0;
            y                <= '0;
          end
        end
        ST_SCAN: begin
          if (edge_memory_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            edge_memory_addr <= edge_memory_addr + 1'b1;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            // The last sample is being added on this same edge, so an
            // empty frame also needs no hit in flight.
            if (count == '0 && !hit) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              found <= 1'b0;
              x_min <= '0;
              x_max <= '0;
              y_min <= '0;
              y_max <= '0;
            end else begin
              state  <= ST_DIV_X;
              div_go <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_DIV_X: begin
          if (div_done) begin
            x_centroid <= quotient;
            state      <= ST_DIV_Y;
            div_go     <= 1'b1;
          end
        end
        ST_DIV_Y: begin
          if (div_done) begin
            y_centroid <= quotient[Y_W-1:0];
            state      <= ST_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            found      <= (count >= MIN_CNT);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_bbox_scan.sv
// Directed + random bench for edge_bbox_scan on a reduced 48x40 frame.
// A BRAM model with two-cycle read latency feeds edge_data.
module tb_edge_bbox_scan;

  localparam int W   = 48;
  localparam int H   = 40;
  localparam int N   = W * H;
  localparam int RL  = 2;
  localparam int MNC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  edge_data;
  logic [18:0] addr;
  logic        busy;
  logic        done;
  logic        found;
  logic [18:0] count;
  logic [9:0]  x_min;
  logic [9:0]  x_max;
  logic [8:0]  y_min;
  logic [8:0]  y_max;
  logic [9:0]  x_centroid;
  logic [8:0]  y_centroid;

  logic [3:0]  img [N];
  logic [3:0]  d1;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;
  int e_xc, e_yc, e_found, e_lat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1        <= img[int'(addr) % N];
    edge_data <= d1;
  end

  edge_bbox_scan #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .READ_LATENCY (RL),
    .MIN_COUNT    (MNC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .edge_data        (edge_data),
    .edge_memory_addr (addr),
    .busy             (busy),
    .done             (done),
    .found            (found),
    .count            (count),
    .x_min            (x_min),
    .x_max            (x_max),
    .y_min            (y_min),
    .y_max            (y_max),
    .x_centroid       (x_centroid),
    .y_centroid       (y_centroid)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) img[i] = 4'd0;
  endtask

  task automatic set_px(input int px, input int py, input int v);
    img[py * W + px] = 4'(v);
  endtask

  task automatic rand_img(input int dens);
    for (int i = 0; i < N; i++)
      img[i] = ($urandom_range(0, 99) < dens) ?
               4'($urandom_range(1, 15)) : 4'd0;
  endtask

  // Reference: walk the frame as an image, no pipeline notion at all.
  task automatic model();
    longint sx, sy;
    sx = 0; sy = 0;
    e_cnt = 0;
    e_xmin = W; e_xmax = -1;
    e_ymin = H; e_ymax = -1;
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        if (img[py * W + px] != 0) begin
          e_cnt++;
          sx += px;
          sy += py;
          if (px < e_xmin) e_xmin = px;
          if (px > e_xmax) e_xmax = px;
          if (py < e_ymin) e_ymin = py;
          if (py > e_ymax) e_ymax = py;
        end
    if (e_cnt == 0) begin
      e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
      e_xc = 0; e_yc = 0; e_found = 0;
      e_lat = 1 + N + RL;
    end else begin
      e_xc = int'(sx / e_cnt);
      e_yc = int'(sy / e_cnt);
      e_found = (e_cnt >= MNC) ? 1 : 0;
      e_lat = 1 + N + RL + 2 * (28 + 2);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":done"}, 32'(done), 0);
    check({tag, ":found"}, 32'(found), 0);
    check({tag, ":count"}, 32'(count), 0);
    check({tag, ":x_min"}, 32'(x_min), 0);
    check({tag, ":x_max"}, 32'(x_max), 0);
    check({tag, ":y_min"}, 32'(y_min), 0);
    check({tag, ":y_max"}, 32'(y_max), 0);
    check({tag, ":xc"}, 32'(x_centroid), 0);
    check({tag, ":yc"}, 32'(y_centroid), 0);
    check({tag, ":addr"}, 32'(addr), 0);
  endtask

  task automatic run_scan(input string tag, input bit toggle);
    int k;
    model();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    k = 1;
    check({tag, ":busy_on"}, 32'(busy), 1);
    check({tag, ":done_drop"}, 32'(done), 0);
    while (!done && k < N + 400) begin
      @(posedge clk); #1;
      k++;
      if (toggle && k == 40) start = 1'b0;
      if (toggle && k == 45) start = 1'b1;
    end
    check({tag, ":latency"}, 32'(k), 32'(e_lat));
    check({tag, ":done"}, 32'(done), 1);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":count"}, 32'(count), 32'(e_cnt));
    check({tag, ":x_min"}, 32'(x_min), 32'(e_xmin));
    check({tag, ":x_max"}, 32'(x_max), 32'(e_xmax));
    check({tag, ":y_min"}, 32'(y_min), 32'(e_ymin));
    check({tag, ":y_max"}, 32'(y_max), 32'(e_ymax));
    check({tag, ":xc"}, 32'(x_centroid), 32'(e_xc));
    check({tag, ":yc"}, 32'(y_centroid), 32'(e_yc));
    check({tag, ":found"}, 32'(found), 32'(e_found));
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, ":hold_done"}, 32'(done), 1);
    check({tag, ":hold_cnt"}, 32'(count), 32'(e_cnt));
    check({tag, ":hold_addr"}, 32'(addr), 32'(N - 1));
  endtask

  initial begin
    clear_img();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_scan("blank", 1'b0);

    clear_img();
    set_px(10, 5, 7);
    run_scan("single", 1'b0);

    clear_img();
    for (int py = 12; py <= 16; py++)
      for (int px = 20; px <= 29; px++)
        set_px(px, py, 1);
    run_scan("rect", 1'b0);

    clear_img();
    set_px(0, 0, 15);
    set_px(W - 1, H - 1, 3);
    run_scan("corners", 1'b0);

    clear_img();
    for (int i = 0; i < MNC - 1; i++) set_px(2 * i, i, 2);
    run_scan("below_min", 1'b0);

    clear_img();
    for (int i = 0; i < MNC; i++) set_px(2 * i + 1, i + 3, 9);
    run_scan("at_min", 1'b0);

    rand_img(20);
    run_scan("toggle", 1'b1);

    rand_img(35);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (N + RL + 10) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_div");
    rst = 1'b0;
    run_scan("after_rst", 1'b0);

    rand_img(5);
    run_scan("restart", 1'b0);

    rand_img(60);
    run_scan("dense", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
